i2c_bus_arbiter: RTL and testbench
==================================

Name: i2c_bus_arbiter

Overview:
- Shares the single open-drain board I2C bus (io_scl/io_sda) between two masters: A = the ADV7511/MAX9850 configuration sender, B = the Amiga-side I2C master inside the Minimig core.
- Replaces the plain wired-AND of both masters' drive enables. Only the granted master's drive reaches the pads.
- Observes START/STOP on the bus so that a grant never changes mid-transaction.
- Enforces bus-free time and a stuck-SCL timeout.

Parameters:
- HOLDOFF_CYCLES, 132: idle cycles (SCL=SDA=1) required before any grant; 4.7 us at 28 MHz.
- TIMEOUT_CYCLES, 700000: cycles of continuous SCL low while granted before forced release; 25 ms at 28 MHz.
- ROUND_ROBIN, 1: 1 = alternate on simultaneous requests; 0 = A always wins.
- SYNC_STAGES, 2: synchroniser depth on the bus inputs.

Ports:
- clk  in  1  system clock (clk_28 domain).
- rst  in  1  asynchronous, active-high reset.
- req_a  in  1  master A requests the bus.
- gnt_a  out  1  master A owns the bus.
- scl_t_a  in  1  master A SCL enable; 0 = drive low.
- sda_t_a  in  1  master A SDA enable; 0 = drive low.
- req_b, gnt_b, scl_t_b, sda_t_b: same as the A ports, for master B.
- bus_scl_i  in  1  raw SCL pad input.
- bus_sda_i  in  1  raw SDA pad input.
- bus_scl_t  out  1  combined SCL enable to the pad; 0 = drive low.
- bus_sda_t  out  1  combined SDA enable to the pad; 0 = drive low.
- busy  out  1  START seen with no STOP yet.
- timeout_err  out  1  sticky stuck-bus flag.
- err_clr  in  1  clears timeout_err.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transfer):
  - gnt_a = gnt_b = 0; bus_scl_t = bus_sda_t = 1 (pads released); busy = 0; timeout_err = 0.
  - State = HOLDOFF, holdoff counter = 0, last_owner = B, so A wins the first tie.
- Input sync: bus_scl_i and bus_sda_i each pass through SYNC_STAGES flops, giving scl_s/sda_s. One extra register holds the previous sampled values.
- Bus condition detect:
  - START = sda_s falls while scl_s = 1 on both samples. Sets busy next cycle.
  - STOP = sda_s rises while scl_s = 1 on both samples. Clears busy next cycle.
  - If START and STOP are both seen in one cycle (impossible on a clean bus), STOP wins.
- Output mux (combinational from the registered grant):
  - gnt_a = 1: bus_*_t = *_t_a.
  - gnt_b = 1: bus_*_t = *_t_b.
  - Neither granted: bus_*_t = 1.
  - gnt_a and gnt_b are never 1 together.
- State machine:
  - HOLDOFF: counter increments while scl_s = 1 and sda_s = 1 and busy = 0; any other condition resets it to 0. At count == HOLDOFF_CYCLES-1, go to IDLE.
  - IDLE: if req_a or req_b is set, grant next cycle (OWN_A or OWN_B).
    - Tie with ROUND_ROBIN = 1: grant the master that is not last_owner.
    - Tie with ROUND_ROBIN = 0: grant A.
    - last_owner updates on each grant.
    - A START seen in IDLE (third-party or misbehaving master) returns to HOLDOFF.
  - OWN_x: gnt_x = 1.
    - Owner drops req_x while busy = 0: go to HOLDOFF next cycle, gnt cleared.
    - Owner drops req_x while busy = 1: go to DRAIN.
  - DRAIN: gnt_x stays 1 so the owner can finish the STOP. On STOP, or busy = 0, go to HOLDOFF.
  - Timeout (applies in OWN_x and DRAIN):
    - A counter increments while scl_s = 0 and resets when scl_s = 1.
    - At TIMEOUT_CYCLES: force gnt = 0, release both lines, set timeout_err, clear busy, go to HOLDOFF.
- Requests:
  - A request arriving during HOLDOFF waits; it is not dropped.
  - A non-owner request never pre-empts the owner.
  - req_x deasserted before its grant: no grant is issued.
- timeout_err: cleared by err_clr on the next cycle. If a timeout and err_clr occur in the same cycle, the set wins.
- Counter widths: $clog2 of the parameter plus 1. Counters saturate and do not wrap.

Decomposition:
- Package i2c_arb_pkg:
  - State encoding: HOLDOFF, IDLE, OWN_A, OWN_B, DRAIN.
  - Owner id constants: OWNER_A, OWNER_B.
  - Default cycle constants for 28 MHz.
- Sub-module i2c_line_monitor: synchroniser plus START/STOP detection and the busy flag. Reused by any future I2C slave/snoop block.

Test Plan:
- Bench parameters: HOLDOFF_CYCLES = 8, TIMEOUT_CYCLES = 64.
1. Reset, bus idle, req_a = 1 at cycle 20 -> gnt_a = 1 at cycle 21 (holdoff completes at cycle 8+sync); bus_scl_t follows scl_t_a on the same cycle.
2. req_a and req_b both high from IDLE -> gnt_a first. A completes START..STOP and drops req -> gnt_b = 1 exactly 8 idle cycles later. Repeat the tie -> gnt_a (round-robin).
3. Owner A drops req mid-byte (busy = 1) -> gnt_a held. A issues STOP -> gnt_a falls; gnt_b is not asserted until 8 idle cycles have passed.
4. Owner B holds scl_t_b = 0 for 64 cycles -> gnt_b = 0, bus_scl_t = bus_sda_t = 1, timeout_err = 1. Pulse err_clr -> timeout_err = 0 next cycle.
5. rst pulsed while A is driving SDA low -> bus_sda_t = 1 and gnt_a = 0 asynchronously (before the next clk edge), busy = 0.
6. With ROUND_ROBIN = 0: repeated ties always grant A. A START injected on the pads while in IDLE -> state returns to HOLDOFF and no grant is issued.

Source files
------------

// File: rtl/i2c_arb_pkg.sv
// Shared types and 28 MHz default timing for the board I2C bus arbiter.
package i2c_arb_pkg;

  typedef enum logic [2:0] {
    HOLDOFF,
    IDLE,
    OWN_A,
    OWN_B,
    DRAIN
  } arb_state_e;

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_e;

  // 4.7 us bus-free time and 25 ms stuck-SCL limit at 28 MHz
  localparam int unsigned DEF_HOLDOFF_CYCLES = 132;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 700000;
  localparam int unsigned DEF_SYNC_STAGES    = 2;

  function automatic owner_e other_owner(input owner_e o);
    return (o == OWNER_A) ? OWNER_B : OWNER_A;
  endfunction

endpackage

// File: rtl/i2c_line_monitor.sv
// Synchronises raw SCL/SDA, detects START/STOP and tracks the bus-busy flag.
module i2c_line_monitor #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  input  logic clr_busy_i,
  output logic scl_s_o,
  output logic sda_s_o,
  output logic start_o,
  output logic stop_o,
  output logic busy_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   busy_q;
  logic                   busy_d;

  assign scl_s_o = scl_sync_q[SYNC_STAGES-1];
  assign sda_s_o = sda_sync_q[SYNC_STAGES-1];

  // Edge conditions need SCL high on both the previous and current sample
  assign start_o = scl_prev_q & scl_s_o &  sda_prev_q & ~sda_s_o;
  assign stop_o  = scl_prev_q & scl_s_o & ~sda_prev_q &  sda_s_o;

  // Busy flag: STOP (or a forced clear) dominates START
  always_comb begin
    busy_d = busy_q;
    if (clr_busy_i || stop_o) begin
      busy_d = 1'b0;
    end else if (start_o) begin
      busy_d = 1'b1;
    end
  end

  // Synchroniser chain plus previous-sample register; resets to released-bus level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
      // which is what makes this a shift chain rather than a single wire.
      scl_sync_q[0] <= scl_i;
      sda_sync_q[0] <= sda_i;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        scl_sync_q[i] <= scl_sync_q[i-1];
        sda_sync_q[i] <= sda_sync_q[i-1];
      end
      scl_prev_q <= scl_s_o;
      sda_prev_q <= sda_s_o;
      busy_q     <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Grants the shared open-drain I2C bus to one of two masters, never mid-transaction.
module i2c_bus_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned ROUND_ROBIN    = 1,
  parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  output logic gnt_a,
  input  logic scl_t_a,
  input  logic sda_t_a,
  input  logic req_b,
  output logic gnt_b,
  input  logic scl_t_b,
  input  logic sda_t_b,
  input  logic bus_scl_i,
  input  logic bus_sda_i,
  output logic bus_scl_t,
  output logic bus_sda_t,
  output logic busy,
  output logic timeout_err,
  input  logic err_clr
);

  localparam int unsigned HO_W = $clog2(HOLDOFF_CYCLES) + 1;
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [HO_W-1:0] HO_LAST = HO_W'(HOLDOFF_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  arb_state_e      state_q, state_d;
  owner_e          owner_q, owner_d;
  owner_e          last_q, last_d;
  owner_e          pick;
  logic [HO_W-1:0] ho_cnt_q, ho_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_q, err_d;

  logic scl_s, sda_s, start_det, stop_det, busy_s;
  logic bus_idle, owned, timeout_hit, clr_busy;

  i2c_line_monitor #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_monitor (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (bus_scl_i),
    .sda_i     (bus_sda_i),
    .clr_busy_i(clr_busy),
    .scl_s_o   (scl_s),
    .sda_s_o   (sda_s),
    .start_o   (start_det),
    .stop_o    (stop_det),
    .busy_o    (busy_s)
  );

  assign bus_idle    = scl_s & sda_s & ~busy_s;
  assign owned       = (state_q == OWN_A) || (state_q == OWN_B) || (state_q == DRAIN);
  assign timeout_hit = owned && !scl_s && (to_cnt_q == TO_LAST);
  assign clr_busy    = timeout_hit;

  // Next-state, counters, ownership bookkeeping and the sticky error flag
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    pick     = OWNER_A;
    ho_cnt_d = '0;
    to_cnt_d = '0;
    err_d    = err_q;

    if (owned && !scl_s) begin
      to_cnt_d = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + 1'b1;
    end

    case (state_q)
      HOLDOFF: begin
        if (bus_idle) begin
          if (ho_cnt_q == HO_LAST) begin
            state_d = IDLE;
          end else begin
            ho_cnt_d = (ho_cnt_q == '1) ? ho_cnt_q : ho_cnt_q + 1'b1;
          end
        end
      end
      IDLE: begin
        // Someone else started a transfer: wait for bus-free time again
        if (start_det) begin
          state_d = HOLDOFF;
        end else if (req_a || req_b) begin
          if (req_a && req_b) begin
            pick = (ROUND_ROBIN != 0) ? other_owner(last_q) : OWNER_A;
          end else begin
            pick = req_a ? OWNER_A : OWNER_B;
          end
          state_d = (pick == OWNER_A) ? OWN_A : OWN_B;
          owner_d = pick;
          last_d  = pick;
        end
      end
      OWN_A: begin
        if (!req_a) state_d = busy_s ? DRAIN : HOLDOFF;
      end
      OWN_B: begin
        if (!req_b) state_d = busy_s ? DRAIN : HOLDOFF;
      end
      DRAIN: begin
        if (stop_det || !busy_s) state_d = HOLDOFF;
      end
      default: state_d = HOLDOFF;
    endcase

    // Stuck SCL overrides everything; a simultaneous clear loses
    if (timeout_hit) begin
      state_d = HOLDOFF;
      err_d   = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= HOLDOFF;
      owner_q  <= OWNER_B;
      last_q   <= OWNER_B;
      ho_cnt_q <= '0;
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      ho_cnt_q <= ho_cnt_d;
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  // Grants decode from registered state, so reset drops them immediately
  assign gnt_a = (state_q == OWN_A) || ((state_q == DRAIN) && (owner_q == OWNER_A));
  assign gnt_b = (state_q == OWN_B) || ((state_q == DRAIN) && (owner_q == OWNER_B));

  assign bus_scl_t   = gnt_a ? scl_t_a : (gnt_b ? scl_t_b : 1'b1);
  assign bus_sda_t   = gnt_a ? sda_t_a : (gnt_b ? sda_t_b : 1'b1);
  assign busy        = busy_s;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Scoreboard bench: stimulus queues expected grant/error events, a monitor
// pops and compares each time a grant or timeout_err rises.
module tb_i2c_bus_arbiter;

  localparam int H = 8;
  localparam int T = 64;
  localparam int S = 2;

  logic       clk;
  logic       rst;
  logic [1:0] req_a, req_b, scl_t_a, sda_t_a, scl_t_b, sda_t_b, err_clr;
  logic [1:0] ext_scl, ext_sda;
  wire  [1:0] gnt_a, gnt_b, bus_scl_t, bus_sda_t, busy, timeout_err;
  wire  [1:0] pad_scl, pad_sda;

  // Open-drain pads with pull-ups; ext_* model a third-party driver
  assign pad_scl = bus_scl_t & ext_scl;
  assign pad_sda = bus_sda_t & ext_sda;

  // Instance 0: round-robin; instance 1: fixed A priority
  i2c_bus_arbiter #(.HOLDOFF_CYCLES(H), .TIMEOUT_CYCLES(T), .ROUND_ROBIN(1), .SYNC_STAGES(S)) u_dut_rr (
    .clk(clk), .rst(rst),
    .req_a(req_a[0]), .gnt_a(gnt_a[0]), .scl_t_a(scl_t_a[0]), .sda_t_a(sda_t_a[0]),
    .req_b(req_b[0]), .gnt_b(gnt_b[0]), .scl_t_b(scl_t_b[0]), .sda_t_b(sda_t_b[0]),
    .bus_scl_i(pad_scl[0]), .bus_sda_i(pad_sda[0]),
    .bus_scl_t(bus_scl_t[0]), .bus_sda_t(bus_sda_t[0]),
    .busy(busy[0]), .timeout_err(timeout_err[0]), .err_clr(err_clr[0])
  );

  i2c_bus_arbiter #(.HOLDOFF_CYCLES(H), .TIMEOUT_CYCLES(T), .ROUND_ROBIN(0), .SYNC_STAGES(S)) u_dut_fp (
    .clk(clk), .rst(rst),
    .req_a(req_a[1]), .gnt_a(gnt_a[1]), .scl_t_a(scl_t_a[1]), .sda_t_a(sda_t_a[1]),
    .req_b(req_b[1]), .gnt_b(gnt_b[1]), .scl_t_b(scl_t_b[1]), .sda_t_b(sda_t_b[1]),
    .bus_scl_i(pad_scl[1]), .bus_sda_i(pad_sda[1]),
    .bus_scl_t(bus_scl_t[1]), .bus_sda_t(bus_sda_t[1]),
    .busy(busy[1]), .timeout_err(timeout_err[1]), .err_clr(err_clr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         dut;
    logic [2:0] snap;  // {gnt_a, gnt_b, timeout_err}
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [2:0] snap_of(input int d);
    return {gnt_a[d], gnt_b[d], timeout_err[d]};
  endfunction

  function automatic logic read_sig(input int d, input int sel);
    case (sel)
      0:       return gnt_a[d];
      1:       return gnt_b[d];
      default: return timeout_err[d];
    endcase
  endfunction

  // Monitor: any rising grant or error flag is a DUT event to score
  logic [2:0] prev_snap [2];
  initial begin
    prev_snap[0] = 3'b000;
    prev_snap[1] = 3'b000;
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst && ((snap_of(d) & ~prev_snap[d]) != 3'b000)) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: dut%0d got %b expected none", d, snap_of(d));
        end else begin
          check($sformatf("event_dut%0d", d), {29'd0, snap_of(d)}, {29'd0, sb_q[0].snap});
          check("event_dut_id", d, sb_q[0].dut);
          void'(sb_q.pop_front());
        end
      end
      prev_snap[d] <= snap_of(d);
    end
  end

  // All stimulus changes land 1 ns after the falling edge
  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    req_a   = '0;
    req_b   = '0;
    scl_t_a = '1;
    sda_t_a = '1;
    scl_t_b = '1;
    sda_t_b = '1;
    err_clr = '0;
    ext_scl = '1;
    ext_sda = '1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic wait_for(input int d, input int sel, input logic val, input int budget,
                          input string name, output int elapsed);
    elapsed = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (read_sig(d, sel) === val) begin
        elapsed = i;
        break;
      end
    end
    check(name, read_sig(d, sel), val);
  endtask

  task automatic push(input int d, input logic [2:0] s);
    exp_t e;
    e.dut  = d;
    e.snap = s;
    sb_q.push_back(e);
  endtask

  // Master A on instance 0: START leaves SCL low
  task automatic a_start();
    scl_t_a[0] = 1'b1; sda_t_a[0] = 1'b1; step(4);
    sda_t_a[0] = 1'b0; step(4);
    scl_t_a[0] = 1'b0; step(2);
  endtask

  task automatic a_bits(input int n);
    for (int i = 0; i < n; i++) begin
      sda_t_a[0] = i[0];
      step(2);
      scl_t_a[0] = 1'b1; step(3);
      scl_t_a[0] = 1'b0; step(2);
    end
  endtask

  task automatic a_stop();
    sda_t_a[0] = 1'b0; step(2);
    scl_t_a[0] = 1'b1; step(4);
    sda_t_a[0] = 1'b1; step(4);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int el;

    // ---- 1: reset state, first grant, pass-through ----
    do_reset();
    check("rst_gnt_a", gnt_a[0], 1'b0);
    check("rst_gnt_b", gnt_b[0], 1'b0);
    check("rst_scl_t", bus_scl_t[0], 1'b1);
    check("rst_sda_t", bus_sda_t[0], 1'b1);
    check("rst_busy", busy[0], 1'b0);
    check("rst_timeout_err", timeout_err[0], 1'b0);
    scl_t_a[0] = 1'b0;
    #1;
    check("ungranted_scl_isolated", bus_scl_t[0], 1'b1);
    scl_t_a[0] = 1'b1;
    step(19);
    push(0, 3'b100);
    req_a[0] = 1'b1;
    wait_for(0, 0, 1'b1, 5, "t1_gnt_a", el);
    check("t1_grant_latency", el, 1);
    scl_t_a[0] = 1'b0; #1;
    check("t1_scl_follows_a", bus_scl_t[0], 1'b0);
    sda_t_a[0] = 1'b0; #1;
    check("t1_sda_follows_a", bus_sda_t[0], 1'b0);
    scl_t_a[0] = 1'b1; sda_t_a[0] = 1'b1;
    req_a[0] = 1'b0;
    step(2);
    check("t1_release", gnt_a[0], 1'b0);

    // ---- 2: tie, handover gap, round-robin ----
    do_reset();
    push(0, 3'b100);
    req_a[0] = 1'b1; req_b[0] = 1'b1;
    wait_for(0, 0, 1'b1, 20, "t2_tie_gnt_a", el);
    check("t2_reset_holdoff", el, H + 1);  // 8 idle holdoff cycles + IDLE grant cycle
    a_start();
    check("t2_busy_after_start", busy[0], 1'b1);
    check("t2_no_preempt", gnt_b[0], 1'b0);
    a_bits(9);
    a_stop();
    check("t2_busy_after_stop", busy[0], 1'b0);
    push(0, 3'b010);
    req_a[0] = 1'b0;
    wait_for(0, 0, 1'b0, 5, "t2_gnt_a_drop", el);
    wait_for(0, 1, 1'b1, 30, "t2_gnt_b", el);
    check("t2_handover_gap", el, H + 1);
    push(0, 3'b100);
    req_b[0] = 1'b0;
    step(1);
    req_a[0] = 1'b1; req_b[0] = 1'b1;
    wait_for(0, 0, 1'b1, 30, "t2_rr_tie_a", el);
    push(0, 3'b010);
    req_a[0] = 1'b0;
    step(1);
    req_a[0] = 1'b1;
    wait_for(0, 1, 1'b1, 30, "t2_rr_tie_b", el);
    push(0, 3'b100);
    req_b[0] = 1'b0;
    step(1);
    req_b[0] = 1'b1;
    wait_for(0, 0, 1'b1, 30, "t2_rr_tie_a_again", el);

    // ---- 3: drop mid-byte, drain until STOP ----
    a_start();
    a_bits(3);
    check("t3_busy_mid_byte", busy[0], 1'b1);
    req_a[0] = 1'b0;
    step(10);
    check("t3_drain_holds_a", gnt_a[0], 1'b1);
    check("t3_drain_no_b", gnt_b[0], 1'b0);
    push(0, 3'b010);
    sda_t_a[0] = 1'b0; step(2);
    scl_t_a[0] = 1'b1; step(4);
    sda_t_a[0] = 1'b1;
    wait_for(0, 0, 1'b0, 10, "t3_gnt_a_after_stop", el);
    wait_for(0, 1, 1'b1, 30, "t3_gnt_b", el);
    check("t3_holdoff_gap", el, H + 1);

    // ---- 4: stuck SCL timeout, sticky flag, clear, set-wins ----
    push(0, 3'b001);
    scl_t_b[0] = 1'b0;
    wait_for(0, 2, 1'b1, 200, "t4_timeout_err", el);
    check("t4_timeout_latency", el, T + S);
    check("t4_gnt_b_forced_off", gnt_b[0], 1'b0);
    check("t4_scl_released", bus_scl_t[0], 1'b1);
    check("t4_sda_released", bus_sda_t[0], 1'b1);
    check("t4_busy_cleared", busy[0], 1'b0);
    step(5);
    check("t4_err_sticky", timeout_err[0], 1'b1);
    scl_t_b[0] = 1'b1; req_b[0] = 1'b0;
    err_clr[0] = 1'b1;
    step(1);
    err_clr[0] = 1'b0;
    check("t4_err_cleared", timeout_err[0], 1'b0);
    push(0, 3'b010);
    req_b[0] = 1'b1;
    wait_for(0, 1, 1'b1, 30, "t4_regrant_b", el);
    err_clr[0] = 1'b1;
    push(0, 3'b001);
    scl_t_b[0] = 1'b0;
    wait_for(0, 2, 1'b1, 200, "t4_set_beats_clear", el);
    check("t4_timeout_latency2", el, T + S);
    step(1);
    check("t4_clear_next_cycle", timeout_err[0], 1'b0);
    err_clr[0] = 1'b0; scl_t_b[0] = 1'b1; req_b[0] = 1'b0;

    // ---- 5: asynchronous reset while A holds SDA low ----
    do_reset();
    push(0, 3'b100);
    req_a[0] = 1'b1;
    wait_for(0, 0, 1'b1, 20, "t5_gnt_a", el);
    a_start();
    check("t5_a_drives_sda", bus_sda_t[0], 1'b0);
    check("t5_busy", busy[0], 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t5_async_sda_release", bus_sda_t[0], 1'b1);
    check("t5_async_scl_release", bus_scl_t[0], 1'b1);
    check("t5_async_gnt_a", gnt_a[0], 1'b0);
    check("t5_async_busy", busy[0], 1'b0);

    // ---- 6: fixed priority and third-party START in IDLE ----
    do_reset();
    push(1, 3'b100);
    req_a[1] = 1'b1; req_b[1] = 1'b1;
    wait_for(1, 0, 1'b1, 20, "t6_tie_a", el);
    for (int k = 0; k < 2; k++) begin
      push(1, 3'b100);
      req_a[1] = 1'b0;
      step(1);
      req_a[1] = 1'b1;
      wait_for(1, 0, 1'b1, 30, $sformatf("t6_tie_a_repeat%0d", k), el);
    end
    req_a[1] = 1'b0; req_b[1] = 1'b0;
    step(H + 4);
    ext_sda[1] = 1'b0;
    step(4);
    check("t6_busy_third_party", busy[1], 1'b1);
    req_a[1] = 1'b1;
    step(20);
    check("t6_no_grant_after_start", gnt_a[1], 1'b0);
    push(1, 3'b100);
    ext_sda[1] = 1'b1;
    wait_for(1, 0, 1'b1, 40, "t6_gnt_after_stop", el);
    check("t6_stop_to_grant", el, S + 2 + H);  // sync, busy clear, holdoff, IDLE grant
    req_a[1] = 1'b0;

    step(5);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
